// File: rtl/dm_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dm_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_ACCESS} arb_state_t;

    localparam int unsigned PORT_CPU  = 0;
    localparam int unsigned PORT_DBG  = 1;
    localparam int unsigned DM_AWIDTH = 32;

    typedef struct packed {
        logic                 we;
        logic [DM_AWIDTH-1:0] addr;
        logic [DM_AWIDTH-1:0] wdata;
    } dm_req_t;

    // Word-aligned and inside the memory's word range.
    function automatic logic dm_addr_ok(input logic [DM_AWIDTH-1:0] addr,
                                        input int unsigned alength);
        return (addr[1:0] == 2'b00) && ((addr >> 2) < alength);
    endfunction

endpackage

// File: rtl/dm_rr_pick.sv
// Combinational two-way round-robin picker; a tie goes to the port not granted last.
module dm_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       winner_o
);

    assign valid_o  = |req_i;
    assign winner_o = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/dm_arbiter.sv
// Serialises CPU and debug-port accesses onto the single data memory as a
// two-cycle grant/access sequence with address checking.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned AWIDTH  = DM_AWIDTH,
    parameter int unsigned ALENGTH = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic [AWIDTH-1:0] p0_addr_i,
    input  logic [AWIDTH-1:0] p0_wdata_i,
    output logic              p0_gnt_o,
    output logic              p0_done_o,
    output logic [AWIDTH-1:0] p0_rdata_o,
    output logic              p0_err_o,
    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic [AWIDTH-1:0] p1_addr_i,
    input  logic [AWIDTH-1:0] p1_wdata_i,
    output logic              p1_gnt_o,
    output logic              p1_done_o,
    output logic [AWIDTH-1:0] p1_rdata_o,
    output logic              p1_err_o,
    output logic              mem_we_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [AWIDTH-1:0] mem_wdata_o,
    input  logic [AWIDTH-1:0] mem_rdata_i
);

    arb_state_t        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              win_q, win_d;
    dm_req_t           acc_q, acc_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [AWIDTH-1:0] rdata_q [2];
    logic [AWIDTH-1:0] rdata_d [2];
    logic              pick_valid, pick_winner;
    logic              acc_ok;

    dm_rr_pick u_pick (
        .req_i    ({p1_req_i, p0_req_i}),
        .last_i   (ptr_q),
        .valid_o  (pick_valid),
        .winner_o (pick_winner)
    );

    assign acc_ok = dm_addr_ok(acc_q.addr, ALENGTH);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        acc_d      = acc_q;
        gnt_d      = '0;
        done_d     = '0;
        err_d      = '0;
        rdata_d[0] = '0;
        rdata_d[1] = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d            = ARB_ACCESS;
                    ptr_d              = pick_winner;
                    win_d              = pick_winner;
                    gnt_d[pick_winner] = 1'b1;
                    if (pick_winner) begin
                        acc_d = '{we: p1_we_i, addr: p1_addr_i, wdata: p1_wdata_i};
                    end else begin
                        acc_d = '{we: p0_we_i, addr: p0_addr_i, wdata: p0_wdata_i};
                    end
                end
            end
            ARB_ACCESS: begin
                state_d       = ARB_IDLE;
                done_d[win_q] = 1'b1;
                err_d[win_q]  = ~acc_ok;
                if (acc_ok && !acc_q.we) begin
                    rdata_d[win_q] = mem_rdata_i;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= 1'b1;
            win_q      <= 1'b0;
            acc_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            acc_q      <= acc_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q[0] <= rdata_d[0];
            rdata_q[1] <= rdata_d[1];
        end
    end

    // Rejected accesses never reach the memory; reset also blocks an in-flight write.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (state_q == ARB_ACCESS && acc_ok) begin
            mem_we_o    = acc_q.we & ~rst_i;
            mem_addr_o  = acc_q.addr;
            mem_wdata_o = acc_q.wdata;
        end
    end

    assign p0_gnt_o   = gnt_q[PORT_CPU];
    assign p0_done_o  = done_q[PORT_CPU];
    assign p0_err_o   = err_q[PORT_CPU];
    assign p0_rdata_o = rdata_q[PORT_CPU];
    assign p1_gnt_o   = gnt_q[PORT_DBG];
    assign p1_done_o  = done_q[PORT_DBG];
    assign p1_err_o   = err_q[PORT_DBG];
    assign p1_rdata_o = rdata_q[PORT_DBG];

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a memory model and a completion scoreboard.
module tb_dm_arbiter;

    logic        clk, rst, load, we_forbid;
    logic        p0_req, p0_we, p0_gnt, p0_done, p0_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_gnt, p1_done, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [128];

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;

    dm_arbiter #(.AWIDTH(32), .ALENGTH(128)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .p0_req_i    (p0_req),
        .p0_we_i     (p0_we),
        .p0_addr_i   (p0_addr),
        .p0_wdata_i  (p0_wdata),
        .p0_gnt_o    (p0_gnt),
        .p0_done_o   (p0_done),
        .p0_rdata_o  (p0_rdata),
        .p0_err_o    (p0_err),
        .p1_req_i    (p1_req),
        .p1_we_i     (p1_we),
        .p1_addr_i   (p1_addr),
        .p1_wdata_i  (p1_wdata),
        .p1_gnt_o    (p1_gnt),
        .p1_done_o   (p1_done),
        .p1_rdata_o  (p1_rdata),
        .p1_err_o    (p1_err),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[8:2]];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
            mem[2]   <= 32'h0BAD_F00D;
            mem[4]   <= 32'hDEAD_BEEF;
            mem[8]   <= 32'hA0A0_A0A0;
            mem[9]   <= 32'hB1B1_B1B1;
            mem[127] <= 32'hCAFE_F00D;
        end else if (mem_we) begin
            mem[mem_addr[8:2]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    task automatic expect_done(input logic port, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.port = port; e.rdata = rdata; e.err = err;
        sb.push_back(e);
    endtask

    // Completion monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("gnt_exclusive", {31'b0, p0_gnt & p1_gnt}, 32'h0);
            check("done_exclusive", {31'b0, p0_done & p1_done}, 32'h0);
            if (we_forbid) check("mem_we_quiet", {31'b0, mem_we}, 32'h0);
            if (p0_done || p1_done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", {30'b0, p1_done, p0_done}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("done_port", {31'b0, p1_done}, {31'b0, e.port});
                    check("done_rdata", e.port ? p1_rdata : p0_rdata, e.rdata);
                    check("done_err", {31'b0, e.port ? p1_err : p0_err}, {31'b0, e.err});
                end
            end
        end
    end

    initial begin
        clk = 0; rst = 1; load = 1; we_forbid = 0;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        cyc();
        load = 0;
        cyc();
        check("rst_gnt", {30'b0, p1_gnt, p0_gnt}, 32'h0);
        check("rst_done", {30'b0, p1_done, p0_done}, 32'h0);
        check("rst_err", {30'b0, p1_err, p0_err}, 32'h0);
        check("rst_rdata", p0_rdata | p1_rdata, 32'h0);
        check("rst_mem", {31'b0, mem_we} | mem_addr | mem_wdata, 32'h0);
        rst = 0;

        // Tie after reset: p0 first, p1 two cycles later.
        drive(0, 1, 1, 32'h0, 32'h11);
        drive(1, 1, 1, 32'h4, 32'h22);
        expect_done(0, 32'h0, 0);
        expect_done(1, 32'h0, 0);
        cyc();
        check("tie_gnt0", {30'b0, p1_gnt, p0_gnt}, 32'h1);
        check("tie_we0", {31'b0, mem_we}, 32'h1);
        check("tie_wdata0", mem_wdata, 32'h11);
        drive(0, 0, 0, 0, 0);
        cyc();
        check("tie_done0", {31'b0, p0_done}, 32'h1);
        cyc();
        check("tie_gnt1", {30'b0, p1_gnt, p0_gnt}, 32'h2);
        check("tie_addr1", mem_addr, 32'h4);
        drive(1, 0, 0, 0, 0);
        cyc();
        check("tie_done1", {31'b0, p1_done}, 32'h1);
        check("tie_mem0", mem[0], 32'h11);
        check("tie_mem1", mem[1], 32'h22);

        // Single read from p0.
        we_forbid = 1;
        drive(0, 1, 0, 32'h10, 32'h0);
        expect_done(0, 32'hDEAD_BEEF, 0);
        cyc();
        check("rd_gnt", {30'b0, p1_gnt, p0_gnt}, 32'h1);
        check("rd_addr", mem_addr, 32'h10);
        drive(0, 0, 0, 0, 0);
        cyc();
        check("rd_done", {30'b0, p1_done, p0_done}, 32'h1);
        check("rd_gnt_clear", {30'b0, p1_gnt, p0_gnt}, 32'h0);

        // Fairness: both ports request continuously; last grant was p0.
        drive(0, 1, 0, 32'h20, 32'h0);
        drive(1, 1, 0, 32'h24, 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) expect_done(1, 32'hB1B1_B1B1, 0);
            else            expect_done(0, 32'hA0A0_A0A0, 0);
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("fair_gnt", {30'b0, p1_gnt, p0_gnt}, (i % 2 == 0) ? 32'h2 : 32'h1);
            cyc();
            if (i == 7) begin
                drive(0, 0, 0, 0, 0);
                drive(1, 0, 0, 0, 0);
            end
        end

        // Rejected accesses: misaligned, then out of range.
        drive(1, 1, 1, 32'h6, 32'h77);
        expect_done(1, 32'h0, 1);
        cyc();
        check("err1_gnt", {30'b0, p1_gnt, p0_gnt}, 32'h2);
        check("err1_addr", mem_addr | mem_wdata, 32'h0);
        drive(1, 0, 0, 0, 0);
        cyc();
        drive(1, 1, 1, 32'h200, 32'h88);
        expect_done(1, 32'h0, 1);
        cyc();
        check("err2_gnt", {30'b0, p1_gnt, p0_gnt}, 32'h2);
        drive(1, 0, 0, 0, 0);
        cyc();
        check("err_mem0", mem[0], 32'h11);
        check("err_mem1", mem[1], 32'h22);

        // Highest legal word is accepted.
        drive(0, 1, 0, 32'h1FC, 32'h0);
        expect_done(0, 32'hCAFE_F00D, 0);
        cyc();
        check("top_gnt", {30'b0, p1_gnt, p0_gnt}, 32'h1);
        drive(0, 0, 0, 0, 0);
        cyc();
        we_forbid = 0;

        // Reset during the ACCESS cycle of a p0 write.
        drive(0, 1, 1, 32'h8, 32'h55);
        cyc();
        check("rmid_gnt", {31'b0, p0_gnt}, 32'h1);
        drive(0, 0, 0, 0, 0);
        rst = 1;
        #1;
        check("rmid_we", {31'b0, mem_we}, 32'h0);
        cyc();
        check("rmid_gnt_after", {30'b0, p1_gnt, p0_gnt}, 32'h0);
        check("rmid_done_after", {30'b0, p1_done, p0_done}, 32'h0);
        check("rmid_err_after", {30'b0, p1_err, p0_err}, 32'h0);
        check("rmid_rdata_after", p0_rdata | p1_rdata, 32'h0);
        check("rmid_mem_after", {31'b0, mem_we} | mem_addr | mem_wdata, 32'h0);
        check("rmid_mem2", mem[2], 32'h0BAD_F00D);
        rst = 0;

        // Pointer is back at port 1, so a fresh tie favours p0.
        drive(0, 1, 0, 32'h10, 32'h0);
        drive(1, 1, 0, 32'h24, 32'h0);
        expect_done(0, 32'hDEAD_BEEF, 0);
        expect_done(1, 32'hB1B1_B1B1, 0);
        cyc();
        check("rtie_gnt0", {30'b0, p1_gnt, p0_gnt}, 32'h1);
        drive(0, 0, 0, 0, 0);
        cyc();
        cyc();
        check("rtie_gnt1", {30'b0, p1_gnt, p0_gnt}, 32'h2);
        drive(1, 0, 0, 0, 0);
        cyc();
        cyc();
        check("sb_drained", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
